aes_in_loader: RTL and testbench
================================

AES_IN_LOADER -- requirements
Module: aes_in_loader

Interface
REQ-001 Parameter BYTE_SWAP, default 0; when 1, the byte order inside each 32-bit input word SHALL be reversed before it is stored.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Port s_data, input, 32: input word.
REQ-005 Port s_valid, input, 1: s_data is valid.
REQ-006 Port s_key_sel, input, 1: 1 marks a key word, 0 marks a plaintext word; it is qualified by s_valid.
REQ-007 Port s_ready, output, 1: the loader accepts a word this cycle; a transfer occurs when s_valid and s_ready are both 1.
REQ-008 Port dn_ready, input, 1: the downstream AES_enc can take a block this cycle.
REQ-009 Port IN_blk, output, 128: assembled plaintext block; drives AES_enc IN.
REQ-010 Port KEY_out, output, 128: assembled key; drives AES_enc KEY.
REQ-011 Port enable, output, 1: one-cycle block-issue strobe; drives AES_enc enable.
REQ-012 Port fsm_en, output, 1: level signal, high while a complete key is loaded; drives AES_enc fsm_en.
REQ-013 Port err_seq, output, 1: sticky sequence-error flag.

Function
REQ-014 Word order SHALL be big-endian: the first word of a group fills bits [127:96] and the fourth fills bits [31:0].
REQ-015 FSM states SHALL be NOKEY, KEYLD, RUN, DATLD and HOLD, with a 2-bit word counter wcnt.
REQ-016 In NOKEY, s_ready=1 only when s_key_sel=1; the first key word SHALL move the FSM to KEYLD.
REQ-017 In KEYLD, the 4th key word SHALL update KEY_out, set fsm_en=1, and move the FSM to RUN.
REQ-018 In RUN, a key word SHALL start a new key load (KEYLD), with the old KEY_out and fsm_en held until that load completes.
REQ-019 In RUN, a data word SHALL start a block (DATLD).
REQ-020 In DATLD, the 4th data word SHALL load IN_blk.
  - If dn_ready=1 in that same cycle: enable=1 on the next cycle and the FSM returns to RUN.
  - Otherwise: the FSM goes to HOLD.
REQ-021 In HOLD, s_ready=0; when dn_ready=1, enable SHALL pulse for 1 cycle and the FSM returns to RUN.
REQ-022 Latency SHALL be exactly 1 cycle from the 4th data-word transfer to the enable pulse when dn_ready=1; IN_blk SHALL be stable while enable=1 and until the next block completes.
REQ-023 If s_key_sel changes value mid-group (KEYLD or DATLD with wcnt≠0):
  - the partial group is discarded and wcnt is cleared;
  - err_seq is set;
  - the offending word is accepted as word 0 of a new group of its own type.
REQ-024 A mid-group switch from KEYLD to data SHALL go to NOKEY if no key was ever loaded, otherwise to DATLD using the old key.
REQ-025 Accepted throughput SHALL be 1 word per cycle; back-to-back blocks SHALL produce an enable every 4 cycles when dn_ready stays at 1.
REQ-026 wcnt SHALL wrap from 3 to 0 on group completion; no other wrap is permitted.

Reset
REQ-027 With rst=0 at a clock edge, the block SHALL enter NOKEY with wcnt=0, IN_blk=0, KEY_out=0, enable=0, fsm_en=0, err_seq=0 and s_ready=0 in the reset cycle.
REQ-028 A reset asserted mid-group or in HOLD SHALL discard all partial and held data; no enable is issued for it.
REQ-029 err_seq SHALL clear only on reset.

Structure
REQ-030 The FSM state encoding, word/block width constants (32, 128) and group length (4) SHALL be placed in shared package aes_pkg.
REQ-031 The block SHALL contain one sub-module, aes_word_packer: a 4×32 shift/assemble register with BYTE_SWAP and clear, instantiated twice (key and data).

Verification
REQ-032 Reset, then key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c -> KEY_out=2b7e151628aed2a6abf7158809cf4f3c and fsm_en=1 on the cycle after the 4th word.
REQ-033 After the key, data words 3243f6a8, 885a308d, 313198a2, e0370734 with dn_ready=1 -> IN_blk=3243f6a8885a308d313198a2e0370734 with enable=1 for exactly 1 cycle, 1 cycle after the 4th word.
REQ-034 Same block with dn_ready=0 for 5 cycles -> s_ready=0 throughout and enable=0; raising dn_ready -> a single enable pulse in the next cycle with IN_blk unchanged.
REQ-035 Data words before any key -> s_ready=0, nothing accepted, err_seq=0.
REQ-036 Two data words followed by a key word -> err_seq=1, the partial block is dropped, and no enable is issued until 4 fresh data words arrive after the key completes.
REQ-037 rst=0 asserted during the 3rd data word -> all outputs return to their reset values; a following full key plus block sequence behaves as in REQ-032 and REQ-033.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, group length, loader FSM encoding and byte-swap helper
package aes_pkg;
    localparam int WORD_W = 32;
    localparam int BLK_W = 128;
    localparam int GRP_LEN = 4;
    localparam logic [1:0] WCNT_LAST = 2'(GRP_LEN - 1);
    typedef enum logic [2:0] {NOKEY, KEYLD, RUN, DATLD, HOLD} state_t;
    function automatic logic [WORD_W-1:0] bswap(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: 4x32 shift/assemble register, blk is the group including the word being loaded
module aes_word_packer import aes_pkg::*; #(
    parameter bit BYTE_SWAP = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic [BLK_W-1:0]  blk
);
    logic [BLK_W-1:0] sh;
    logic [WORD_W-1:0] w;
    assign w = BYTE_SWAP ? bswap(word) : word;
    assign blk = {sh[BLK_W-WORD_W-1:0], w};
    always_ff @(posedge clk) begin
        if (!rst) sh <= '0;
        else if (load) sh <= {(clr ? {(BLK_W-WORD_W){1'b0}} : sh[BLK_W-WORD_W-1:0]), w};
        else if (clr) sh <= '0;
    end
endmodule

// File: rtl/aes_in_loader.sv
// aes_in_loader: assembles 32-bit key/plaintext words into 128-bit blocks for AES_enc
module aes_in_loader import aes_pkg::*; #(
    parameter bit BYTE_SWAP = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_key_sel,
    output logic              s_ready,
    input  logic              dn_ready,
    output logic [BLK_W-1:0]  IN_blk,
    output logic [BLK_W-1:0]  KEY_out,
    output logic              enable,
    output logic              fsm_en,
    output logic              err_seq
);
    state_t st;
    logic [1:0] wcnt;
    logic acc, first;
    logic [BLK_W-1:0] key_blk, dat_blk;
    assign s_ready = rst && (st == NOKEY ? s_key_sel : st != HOLD);
    assign acc = s_valid && s_ready;
    // Any group start (fresh or after a type switch) discards both partial groups
    assign first = acc && (st == NOKEY || st == RUN || (st == KEYLD && !s_key_sel) || (st == DATLD && s_key_sel));
    aes_word_packer #(.BYTE_SWAP(BYTE_SWAP)) u_key (
        .clk(clk), .rst(rst), .clr(first), .load(acc && s_key_sel), .word(s_data), .blk(key_blk)
    );
    aes_word_packer #(.BYTE_SWAP(BYTE_SWAP)) u_dat (
        .clk(clk), .rst(rst), .clr(first), .load(acc && !s_key_sel), .word(s_data), .blk(dat_blk)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            st <= NOKEY;
            wcnt <= '0;
            IN_blk <= '0;
            KEY_out <= '0;
            enable <= 1'b0;
            fsm_en <= 1'b0;
            err_seq <= 1'b0;
        end else begin
            enable <= 1'b0;
            case (st)
                NOKEY: if (acc) begin
                    st <= KEYLD;
                    wcnt <= 2'd1;
                end
                KEYLD: if (acc) begin
                    if (!s_key_sel) begin
                        err_seq <= 1'b1;
                        st <= fsm_en ? DATLD : NOKEY;
                        wcnt <= fsm_en ? 2'd1 : 2'd0;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                        if (wcnt == WCNT_LAST) begin
                            KEY_out <= key_blk;
                            fsm_en <= 1'b1;
                            st <= RUN;
                        end
                    end
                end
                RUN: if (acc) begin
                    st <= s_key_sel ? KEYLD : DATLD;
                    wcnt <= 2'd1;
                end
                DATLD: if (acc) begin
                    if (s_key_sel) begin
                        err_seq <= 1'b1;
                        st <= KEYLD;
                        wcnt <= 2'd1;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                        if (wcnt == WCNT_LAST) begin
                            IN_blk <= dat_blk;
                            enable <= dn_ready;
                            st <= dn_ready ? RUN : HOLD;
                        end
                    end
                end
                HOLD: if (dn_ready) begin
                    enable <= 1'b1;
                    st <= RUN;
                end
                default: st <= NOKEY;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_in_loader.sv
// tb_aes_in_loader: directed stimulus checked every cycle against a queue-based model
module tb_aes_in_loader;
    logic clk = 1'b0;
    logic rst, s_valid, s_key_sel, s_ready, dn_ready, enable, fsm_en, err_seq;
    logic [31:0] s_data;
    logic [127:0] IN_blk, KEY_out;
    int tests = 0, fails = 0;
    logic [31:0] kq[$], dq[$];
    logic [127:0] m_key, m_blk;
    logic m_have_key, m_pending, m_en, m_err;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BLK1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

    aes_in_loader dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_key_sel(s_key_sel),
        .s_ready(s_ready), .dn_ready(dn_ready), .IN_blk(IN_blk), .KEY_out(KEY_out),
        .enable(enable), .fsm_en(fsm_en), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic exp_ready();
        return rst && !m_pending && (s_key_sel || m_have_key || kq.size() != 0);
    endfunction

    task automatic model_step();
        logic acc;
        acc = s_valid && exp_ready();
        if (!rst) begin
            kq.delete(); dq.delete();
            m_key = '0; m_blk = '0;
            m_have_key = 0; m_pending = 0; m_en = 0; m_err = 0;
        end else begin
            m_en = 0;
            if (m_pending) begin
                if (dn_ready) begin m_en = 1; m_pending = 0; end
            end else if (acc && s_key_sel) begin
                if (dq.size() != 0) begin m_err = 1; dq.delete(); end
                kq.push_back(s_data);
                if (kq.size() == 4) begin
                    m_key = {kq[0], kq[1], kq[2], kq[3]};
                    m_have_key = 1;
                    kq.delete();
                end
            end else if (acc) begin
                if (kq.size() != 0) begin m_err = 1; kq.delete(); end
                if (m_have_key) begin
                    dq.push_back(s_data);
                    if (dq.size() == 4) begin
                        m_blk = {dq[0], dq[1], dq[2], dq[3]};
                        dq.delete();
                        if (dn_ready) m_en = 1; else m_pending = 1;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("s_ready", s_ready, exp_ready());
        chk("enable", enable, m_en);
        chk("IN_blk", IN_blk, m_blk);
        chk("KEY_out", KEY_out, m_key);
        chk("fsm_en", fsm_en, m_have_key);
        chk("err_seq", err_seq, m_err);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [31:0] w, input logic k);
        s_valid = 1; s_data = w; s_key_sel = k;
        @(posedge clk);
        #1;
        s_valid = 0;
    endtask

    task automatic grp(input logic [127:0] b, input logic k);
        for (int i = 0; i < 4; i++) word(b[127-32*i -: 32], k);
    endtask

    initial begin
        rst = 0; s_valid = 0; s_data = '0; s_key_sel = 0; dn_ready = 1;
        idle(2);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_key", KEY_out, 128'h0);
        rst = 1;
        s_valid = 1; s_key_sel = 0; s_data = 32'h11111111;
        #1;
        chk("nokey_ready", s_ready, 1'b0);
        idle(3);
        chk("nokey_err", err_seq, 1'b0);
        s_valid = 0;
        grp(KEY1, 1);
        chk("key1_lit", KEY_out, KEY1);
        chk("key1_fsm_en", fsm_en, 1'b1);
        grp(BLK1, 0);
        chk("blk1_en", enable, 1'b1);
        chk("blk1_lit", IN_blk, BLK1);
        idle(1);
        chk("blk1_en_off", enable, 1'b0);
        grp(128'h00112233445566778899aabbccddeeff, 0);
        grp(128'hffeeddccbbaa99887766554433221100, 0);
        chk("b2b_en", enable, 1'b1);
        idle(1);
        dn_ready = 0;
        grp(BLK1, 0);
        s_valid = 1; s_key_sel = 0; s_data = 32'hdeadbeef;
        for (int i = 0; i < 5; i++) begin
            chk("hold_ready", s_ready, 1'b0);
            chk("hold_en", enable, 1'b0);
            idle(1);
        end
        s_valid = 0; dn_ready = 1;
        idle(1);
        chk("hold_pulse", enable, 1'b1);
        chk("hold_blk", IN_blk, BLK1);
        idle(1);
        chk("hold_pulse_off", enable, 1'b0);
        word(32'haaaa0001, 0);
        word(32'haaaa0002, 0);
        word(KEY2[127:96], 1);
        chk("sw_err", err_seq, 1'b1);
        word(KEY2[95:64], 1);
        word(KEY2[63:32], 1);
        word(KEY2[31:0], 1);
        chk("sw_key", KEY_out, KEY2);
        chk("sw_no_en", enable, 1'b0);
        grp(BLK1, 0);
        chk("sw_fresh_en", enable, 1'b1);
        word(32'h55550001, 1);
        word(32'h55550002, 1);
        grp(128'h0badf00d0badf00d0badf00d0badf00d, 0);
        chk("kd_sw_en", enable, 1'b1);
        chk("kd_sw_key", KEY_out, KEY2);
        grp(KEY1, 1);
        word(BLK1[127:96], 0);
        word(BLK1[95:64], 0);
        s_valid = 1; s_key_sel = 0; s_data = BLK1[63:32]; rst = 0;
        idle(1);
        s_valid = 0;
        chk("mid_rst_key", KEY_out, 128'h0);
        chk("mid_rst_blk", IN_blk, 128'h0);
        chk("mid_rst_fsm", fsm_en, 1'b0);
        chk("mid_rst_err", err_seq, 1'b0);
        chk("mid_rst_ready", s_ready, 1'b0);
        rst = 1;
        grp(KEY1, 1);
        chk("re_key", KEY_out, KEY1);
        grp(BLK1, 0);
        chk("re_en", enable, 1'b1);
        chk("re_blk", IN_blk, BLK1);
        rst = 0;
        idle(1);
        rst = 1;
        word(32'h77770001, 1);
        word(32'h77770002, 1);
        word(32'h77770003, 0);
        chk("nk_sw_err", err_seq, 1'b1);
        chk("nk_sw_fsm", fsm_en, 1'b0);
        s_valid = 1; s_key_sel = 0;
        #1;
        chk("nk_sw_ready", s_ready, 1'b0);
        s_valid = 0;
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
